// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
// Holds opcode/funct constants, ALU control codes, datapath mux encodings,
// the 4-bit FSM state encoding and the ALU-decode class handed to mips_alu_dec.
package mips_mc_pkg;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type function fields
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU control codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU B operand source
  localparam logic [2:0] SrcBReg    = 3'b000;
  localparam logic [2:0] SrcBFour   = 3'b001;
  localparam logic [2:0] SrcBSext   = 3'b010;
  localparam logic [2:0] SrcBSextSh = 3'b011;
  localparam logic [2:0] SrcBZext   = 3'b100;

  // PC source
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StImmEx  = 4'd9,
    StImmWb  = 4'd10,
    StJump   = 4'd11
  } state_e;

  // What kind of ALU operation the current state wants; the decoder turns this
  // (plus funct for R-type) into the 3-bit ALU control.
  typedef enum logic [2:0] {
    ClsAdd,
    ClsSub,
    ClsAnd,
    ClsOr,
    ClsFunct
  } alu_cls_e;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU control decoder for the multicycle MIPS sequencer.
// Ports:
//   cls_i      - operation class requested by the current FSM state
//   funct_i    - R-type function field, only consulted for ClsFunct
//   alu_ctrl_o - 3-bit ALU function select
module mips_alu_dec
  import mips_mc_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = AluAdd;
    case (cls_i)
      ClsAdd: alu_ctrl_o = AluAdd;
      ClsSub: alu_ctrl_o = AluSub;
      ClsAnd: alu_ctrl_o = AluAnd;
      ClsOr:  alu_ctrl_o = AluOr;
      ClsFunct: begin
        case (funct_i)
          FnAdd:   alu_ctrl_o = AluAdd;
          FnSub:   alu_ctrl_o = AluSub;
          FnAnd:   alu_ctrl_o = AluAnd;
          FnOr:    alu_ctrl_o = AluOr;
          FnSlt:   alu_ctrl_o = AluSlt;
          // Unsupported funct values fall back to AND
          default: alu_ctrl_o = AluAnd;
        endcase
      end
      default: alu_ctrl_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_mcp_ctrl.sv
// Multicycle MIPS control sequencer. Moore-style FSM stepping each instruction
// through fetch/decode/execute/memory/write-back, driving every datapath mux,
// write enable and memory request. Memory phases wait on mem_ready.
// Ports:
//   clk, rst (async active-low)
//   op, funct        - instruction register fields
//   zero             - ALU zero flag (used in BRANCH)
//   mem_ready        - memory handshake for fetch/load/store
//   mem_req, mem_we, iord                   - memory port control
//   ir_write, pc_en, pc_src                 - IR / PC control
//   reg_w, reg_d, mem_to_reg                - register file write-back
//   alu_src_a, alu_src_b, alu_ctrl          - ALU operand/function select
//   state, retire, illegal                  - debug / status
module mips_mcp_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_w,
  output logic       reg_d,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  state_e   state_q, state_d;
  alu_cls_e alu_cls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_cls    = ClsAdd;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PcSrcAlu;
    reg_w      = 1'b0;
    reg_d      = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SrcBFour;
        // PC+4 and IR load happen only on the cycle the fetch completes
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut
        alu_src_b = SrcBSextSh;
        case (op)
          OpLw, OpSw:             state_d = StMemAdr;
          OpRtype:                state_d = StExec;
          OpBeq:                  state_d = StBranch;
          OpAddi, OpAndi, OpOri:  state_d = StImmEx;
          OpJ:                    state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBSext;
        state_d   = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBReg;
        alu_cls   = ClsFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_w   = 1'b1;
        reg_d   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBReg;
        alu_cls   = ClsSub;
        pc_src    = PcSrcAluOut;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StImmEx: begin
        alu_src_a = 1'b1;
        case (op)
          OpAndi: begin
            alu_src_b = SrcBZext;
            alu_cls   = ClsAnd;
          end
          OpOri: begin
            alu_src_b = SrcBZext;
            alu_cls   = ClsOr;
          end
          default: begin
            alu_src_b = SrcBSext;
            alu_cls   = ClsAdd;
          end
        endcase
        state_d = StImmWb;
      end
      StImmWb: begin
        reg_w   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJump: begin
        pc_src  = PcSrcJump;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: begin
        // Unused encodings: everything off (ALU control 000) and recover
        alu_cls = ClsAnd;
        state_d = StFetch;
      end
    endcase

    // Reset gates every side-effecting output combinationally so an asserted
    // rst kills an in-flight store in the same cycle, before the flop clears.
    if (!rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_write = 1'b0;
      pc_en    = 1'b0;
      reg_w    = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  mips_alu_dec u_alu_dec (
    .cls_i      (alu_cls),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl)
  );

  assign state = state_q;

endmodule

// File: tb/tb_mips_mcp_ctrl.sv
// Self-checking bench for mips_mcp_ctrl: directed cases plus randomized
// instruction streams with random memory stalls, checked cycle by cycle
// against a behavioural model of the per-state control table.
module tb_mips_mcp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       reg_w, reg_d, mem_to_reg, alu_src_a;
  logic [2:0] alu_src_b, alu_ctrl;
  logic [3:0] state;
  logic       retire, illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_mcp_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .reg_w      (reg_w),
    .reg_d      (reg_d),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .state      (state),
    .retire     (retire),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_w;
    logic       reg_d;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       retire;
    logic       illegal;
  } ctl_t;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    case (o)
      6'b100011, 6'b101011, 6'b000000, 6'b000100,
      6'b001000, 6'b001100, 6'b001101, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Control table of the sequencer, one row per state number.
  function automatic ctl_t model_ctl(input int st, input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input logic r);
    ctl_t c;
    c = '0;
    c.alu_ctrl = 3'b010;
    case (st)
      0: begin c.mem_req = 1; c.alu_src_b = 3'b001; c.ir_write = r; c.pc_en = r; end
      1: begin c.alu_src_b = 3'b011; c.illegal = !is_legal(o); end
      2: begin c.alu_src_a = 1; c.alu_src_b = 3'b010; end
      3: begin c.mem_req = 1; c.iord = 1; end
      4: begin c.reg_w = 1; c.mem_to_reg = 1; c.retire = 1; end
      5: begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; c.retire = r; end
      6: begin c.alu_src_a = 1; c.alu_ctrl = funct_alu(f); end
      7: begin c.reg_w = 1; c.reg_d = 1; c.retire = 1; end
      8: begin
        c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_en = z; c.retire = 1;
      end
      9: begin
        c.alu_src_a = 1;
        if (o == 6'b001100) begin c.alu_src_b = 3'b100; c.alu_ctrl = 3'b000; end
        else if (o == 6'b001101) begin c.alu_src_b = 3'b100; c.alu_ctrl = 3'b001; end
        else c.alu_src_b = 3'b010;
      end
      10: begin c.reg_w = 1; c.retire = 1; end
      11: begin c.pc_src = 2'b10; c.pc_en = 1; c.retire = 1; end
      default: c.alu_ctrl = 3'b000;
    endcase
    return c;
  endfunction

  function automatic int base_latency(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  int  seq[$];
  bit  rdy[$];

  task automatic push_mem(input int st, input int nstall);
    for (int k = 0; k < nstall; k++) begin seq.push_back(st); rdy.push_back(1'b0); end
    seq.push_back(st);
    rdy.push_back(1'b1);
  endtask

  task automatic push_plain(input int st);
    seq.push_back(st);
    rdy.push_back(1'($urandom));
  endtask

  // Runs one instruction; entered at posedge+1 with the DUT in FETCH.
  // zmode: 0/1 hold zero at that value, 2 randomize every cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fs,
                           input int ms, input int zmode);
    int   done_at;
    int   pulses;
    int   stalls;
    ctl_t exp_c, obs_c;
    seq.delete();
    rdy.delete();
    push_mem(0, fs);
    push_plain(1);
    stalls = fs;
    case (o)
      6'b100011: begin push_plain(2); push_mem(3, ms); push_plain(4); stalls += ms; end
      6'b101011: begin push_plain(2); push_mem(5, ms); stalls += ms; end
      6'b000000: begin push_plain(6); push_plain(7); end
      6'b000100: push_plain(8);
      6'b001000, 6'b001100, 6'b001101: begin push_plain(9); push_plain(10); end
      6'b000010: push_plain(11);
      default: ;
    endcase
    op = o;
    funct = f;
    done_at = -1;
    pulses = 0;
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = rdy[i];
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      exp_c = model_ctl(seq[i], o, f, zero, mem_ready);
      obs_c = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_w, reg_d, mem_to_reg,
               alu_src_a, alu_src_b, alu_ctrl, retire, illegal};
      check_eq($sformatf("state op=%b c%0d", o, i), {28'd0, state}, seq[i]);
      check_eq($sformatf("ctl op=%b st=%0d", o, seq[i]), {13'd0, obs_c}, {13'd0, exp_c});
      if (retire || illegal) begin
        pulses++;
        done_at = i + 1;
      end
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("latency op=%b", o), done_at, base_latency(o) + stalls);
    check_eq($sformatf("pulses op=%b", o), pulses, 1);
  endtask

  task automatic cyc(input logic r, input int st);
    mem_ready = r;
    zero = 1'($urandom);
    @(negedge clk);
    check_eq("seq_state", {28'd0, state}, st);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legal_ops [9];
  logic [5:0] functs [6];

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] o, f;
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b001000,
                  6'b001100, 6'b001101, 6'b000010};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    // Reset held for 3 cycles with ready asserted: nothing may leak out
    rst = 1'b0;
    op = 6'b100011;
    funct = 6'd0;
    zero = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_state", {28'd0, state}, 0);
      check_eq("rst_enables", {25'd0, mem_req, mem_we, ir_write, pc_en, reg_w, retire, illegal},
               0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check_eq("post_rst_state", {28'd0, state}, 0);
    check_eq("post_rst_mem_req", {31'd0, mem_req}, 1);

    // Directed cases
    run_instr(6'b000000, 6'b100000, 0, 0, 2);  // R-type add
    run_instr(6'b100011, 6'b000000, 0, 2, 2);  // lw, 2 stall cycles in MEMRD
    run_instr(6'b000100, 6'b000000, 0, 0, 1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, 0, 0);  // beq not taken
    run_instr(6'b111111, 6'b000000, 0, 0, 2);  // illegal opcode
    run_instr(6'b101011, 6'b000000, 1, 3, 2);  // sw with stalls
    run_instr(6'b001101, 6'b000000, 0, 0, 2);  // ori
    run_instr(6'b001100, 6'b000000, 0, 0, 2);  // andi

    // Reset pulsed during a stalled store
    op = 6'b101011;
    cyc(1'b1, 0);
    cyc(1'b0, 1);
    cyc(1'b1, 2);
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("sw_memwr_state", {28'd0, state}, 5);
    check_eq("sw_memwr_we", {31'd0, mem_we}, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_we", {31'd0, mem_we}, 0);
    check_eq("midrst_req", {31'd0, mem_req}, 0);
    check_eq("midrst_state", {28'd0, state}, 0);
    check_eq("midrst_retire", {31'd0, retire}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_release_req", {31'd0, mem_req}, 1);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      else o = legal_ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = functs[$urandom_range(0, 5)];
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), 2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mcp_ctrl.md
# mips_mcp_ctrl

- Multicycle control sequencer for the MIPS core; the core reuses one ALU and one unified memory port across several cycles per instruction.
- Decodes the opcode held in the datapath's instruction register, steps through a Moore-style FSM, and drives every datapath mux, write enable and memory request.
- Waits on a memory ready handshake for instruction fetch, load and store.
- Sits between the instruction register/ALU flags and the multicycle datapath.

## Interface
Parameters:
- none (all encodings are fixed constants; see Structure)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  6  opcode from instruction register; stable from DECODE until the next FETCH completes
- funct  in  6  function field from instruction register
- zero  in  1  ALU zero flag, combinational from the current ALU inputs
- mem_ready  in  1  memory accepts the write, or returns read data, this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write; only asserted together with mem_req
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_en  out  1  PC register load enable
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- reg_w  out  1  register file write
- reg_d  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = memory data register
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = register A
- alu_src_b  out  3  ALU B source: 000 = register B, 001 = constant 4, 010 = sign-extended imm, 011 = sign-extended imm<<2, 100 = zero-extended imm
- alu_ctrl  out  3  ALU function: AND = 000, OR = 001, ADD = 010, SUB = 110, SLT = 111
- state  out  4  current state, for debug
- retire  out  1  one-cycle pulse on the final cycle of each legal instruction
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
State encoding and per-state behaviour. Any output not listed for a state is 0; alu_ctrl defaults to ADD.
- 0 FETCH
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=001, alu_ctrl=ADD, pc_src=00; ir_write = pc_en = mem_ready.
  - Next: stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- 1 DECODE
  - Outputs: alu_src_a=0, alu_src_b=011, alu_ctrl=ADD (branch target is captured into ALUOut).
  - Next, by op:
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 → EXEC
    - beq 000100 → BRANCH
    - addi 001000 / andi 001100 / ori 001101 → IMMEX
    - j 000010 → JUMP
    - any other opcode → FETCH, with illegal=1
- 2 MEMADR
  - Outputs: alu_src_a=1, alu_src_b=010, alu_ctrl=ADD.
  - Next: MEMRD for lw, MEMWR for sw.
- 3 MEMRD
  - Outputs: mem_req=1, iord=1.
  - Next: waits for mem_ready, then MEMWB.
- 4 MEMWB
  - Outputs: reg_w=1, reg_d=0, mem_to_reg=1, retire=1.
  - Next: FETCH.
- 5 MEMWR
  - Outputs: mem_req=1, mem_we=1, iord=1; retire = mem_ready.
  - Next: waits for mem_ready, then FETCH.
- 6 EXEC
  - Outputs: alu_src_a=1, alu_src_b=000, alu_ctrl decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, any other AND.
  - Next: ALUWB.
- 7 ALUWB
  - Outputs: reg_w=1, reg_d=1, mem_to_reg=0, retire=1.
  - Next: FETCH.
- 8 BRANCH
  - Outputs: alu_src_a=1, alu_src_b=000, alu_ctrl=SUB, pc_src=01, pc_en=zero, retire=1.
  - Next: FETCH.
- 9 IMMEX
  - Outputs: alu_src_a=1.
    - addi: alu_src_b=010, alu_ctrl=ADD.
    - andi: alu_src_b=100, alu_ctrl=AND.
    - ori: alu_src_b=100, alu_ctrl=OR.
  - Next: IMMWB.
- 10 IMMWB
  - Outputs: reg_w=1, reg_d=0, mem_to_reg=0, retire=1.
  - Next: FETCH.
- 11 JUMP
  - Outputs: pc_src=10, pc_en=1, retire=1.
  - Next: FETCH.
- Unused encodings 12–15: all outputs 0; next state FETCH.

## Timing
- Reset:
  - While rst=0, state=FETCH.
  - pc_en, ir_write, reg_w, mem_we, mem_req, retire and illegal are forced 0.
  - After rst deasserts, the first FETCH request appears in the same cycle.
- State register updates on the rising edge of clk. All outputs are combinational from state, op, funct, zero and mem_ready, with no added latency.
- Latency with mem_ready held at 1:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - addi/andi/ori 4 cycles
  - beq 3 cycles
  - j 3 cycles
  - illegal opcode 2 cycles
- Every cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_req, iord and mem_we are held constant until the access completes.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately, and no partial write is issued.

## Structure
- Package mips_mc_pkg holds:
  - opcode and funct constants
  - alu_ctrl codes
  - alu_src_b and pc_src encodings
  - 4-bit state encoding
- One sub-module, mips_alu_dec: decodes funct and the state class into alu_ctrl. The FSM and output decode stay in the top module.

## Test plan
- Reset with rst=0 for 3 cycles, then release → state=0, mem_req=1 in the first cycle after release; no write enable asserted during reset.
- R-type add (op=000000, funct=100000), mem_ready=1 → states 0,1,6,7; alu_ctrl=010 in EXEC; reg_w=1, reg_d=1 and retire=1 in cycle 4.
- lw with mem_ready=0 for 2 cycles in MEMRD → states 0,1,2,3,3,3,4; total 7 cycles; mem_to_reg=1 only in MEMWB.
- beq with zero=1, then with zero=0 → pc_en=1 and pc_src=01 in BRANCH for the first case; pc_en=0 for the second; both take 3 cycles.
- op=111111 → illegal pulses once in DECODE; the FSM is back in FETCH on the next cycle; retire stays 0.
- sw with mem_ready=0, rst pulsed low during MEMWR → mem_we drops immediately, state=0, no retire pulse.
